// File: rtl/pipe_stage_chain.sv
// Pipeline-register chain with per-stage hold, bubble insertion behind held stages,
// per-stage flush, occupancy popcount and saturating stall/flush statistics.
module pipe_stage_chain #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 3,
  parameter bit          BUBBLE_ZERO = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           stall_vec,
  input  logic [DEPTH-1:0]           flush_vec,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A stalled older stage freezes everything younger so no entry is overwritten.
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = stall_vec[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hold[i] = hold[i+1] | stall_vec[i];
    end
  end

  assign in_ready = ~hold[0];

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end

    if (flush_vec[0]) begin
      valid_d[0] = 1'b0;
      if (BUBBLE_ZERO) data_d[0] = '0;
    end else if (!hold[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (flush_vec[i]) begin
        valid_d[i] = 1'b0;
        if (BUBBLE_ZERO) data_d[i] = '0;
      end else if (hold[i]) begin
        valid_d[i] = valid_q[i];
      end else if (hold[i-1]) begin
        // Upstream is held but this stage advances: emit a bubble.
        valid_d[i] = 1'b0;
        if (BUBBLE_ZERO) data_d[i] = '0;
      end else begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (|(flush_vec & valid_q) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    stage_data = '0;
    occupancy  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_data[i*WIDTH +: WIDTH] = data_q[i];
      occupancy = occupancy + OccW'(valid_q[i]);
    end
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: a zeroing chain with 4-bit counters and a payload-retaining chain
// with 16-bit counters share the same stimulus.
module tb_pipe_stage_chain;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [DEPTH-1:0]       stall_vec;
  logic [DEPTH-1:0]       flush_vec;

  logic                   in_ready, out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [1:0]             occupancy;
  logic [3:0]             stall_cnt, flush_cnt;

  logic                   nz_in_ready, nz_out_valid;
  logic [WIDTH-1:0]       nz_out_data;
  logic [DEPTH-1:0]       nz_stage_valid;
  logic [DEPTH*WIDTH-1:0] nz_stage_data;
  logic [1:0]             nz_occupancy;
  logic [15:0]            nz_stall_cnt, nz_flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BUBBLE_ZERO(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_vec(stall_vec), .flush_vec(flush_vec),
    .out_valid(out_valid), .out_data(out_data), .stage_valid(stage_valid),
    .stage_data(stage_data), .occupancy(occupancy), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BUBBLE_ZERO(1'b0), .CNT_W(16)) u_dut_nz (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(nz_in_ready), .stall_vec(stall_vec), .flush_vec(flush_vec),
    .out_valid(nz_out_valid), .out_data(nz_out_data), .stage_valid(nz_stage_valid),
    .stage_data(nz_stage_data), .occupancy(nz_occupancy), .stall_cnt(nz_stall_cnt),
    .flush_cnt(nz_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    stall_vec = '0;
    flush_vec = '0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("reset_stage_valid", 128'(stage_valid), 128'(3'b000));
    chk("reset_out_valid",   128'(out_valid),   128'(1'b0));
    chk("reset_occupancy",   128'(occupancy),   128'(2'd0));
    chk("reset_counters",    128'({stall_cnt, flush_cnt}), 128'(8'h00));
    chk("reset_in_ready",    128'(in_ready),    128'(1'b1));

    // Fill: 0x11 accepted at edge 1 reaches the output after edge 3.
    in_valid = 1'b1;
    in_data  = 32'h11;
    tick();
    chk("fill1_stage_valid", 128'(stage_valid), 128'(3'b001));
    in_data = 32'h22;
    tick();
    chk("fill2_out_valid", 128'(out_valid), 128'(1'b0));
    in_data = 32'h33;
    tick();
    chk("fill3_out", 128'({out_valid, out_data}), 128'({1'b1, 32'h11}));
    chk("fill3_stage_data", 128'(stage_data), 128'({32'h11, 32'h22, 32'h33}));
    chk("fill3_occupancy", 128'(occupancy), 128'(2'd3));

    // Stall stage 0 for one edge: s1 becomes a bubble, s2 takes B.
    in_data   = 32'h44;
    stall_vec = 3'b001;
    #1;
    chk("stall0_in_ready", 128'(in_ready), 128'(1'b0));
    tick();
    chk("stall0_stage_valid", 128'(stage_valid), 128'(3'b101));
    chk("stall0_stage_data",  128'(stage_data),  128'({32'h22, 32'h00, 32'h33}));
    chk("stall0_stall_cnt",   128'(stall_cnt),   128'(4'd1));
    chk("stall0_nz_data",     128'(nz_stage_data), 128'({32'h22, 32'h22, 32'h33}));
    chk("stall0_nz_valid",    128'(nz_stage_valid), 128'(3'b101));

    stall_vec = 3'b000;
    tick();
    chk("resume_stage_valid", 128'(stage_valid), 128'(3'b011));
    chk("resume_stage_data",  128'(stage_data),  128'({32'h00, 32'h33, 32'h44}));
    in_data = 32'h55;
    tick();
    chk("refill_stage_data", 128'(stage_data), 128'({32'h33, 32'h44, 32'h55}));
    chk("refill_stall_cnt",  128'(stall_cnt),  128'(4'd1));

    // Oldest-stage stall freezes the whole chain.
    in_data   = 32'h66;
    stall_vec = 3'b100;
    #1;
    chk("allstall_in_ready", 128'(in_ready), 128'(1'b0));
    tick();
    tick();
    tick();
    chk("allstall_stage_data", 128'(stage_data), 128'({32'h33, 32'h44, 32'h55}));
    chk("allstall_occupancy",  128'(occupancy),  128'(2'd3));
    chk("allstall_stall_cnt",  128'(stall_cnt),  128'(4'd4));

    // Flush s0/s1 while s0 is stalled: s2 still advances from s1 before it clears.
    stall_vec = 3'b001;
    flush_vec = 3'b011;
    tick();
    chk("flush_stage_valid", 128'(stage_valid), 128'(3'b100));
    chk("flush_stage_data",  128'(stage_data),  128'({32'h44, 32'h00, 32'h00}));
    chk("flush_out_data",    128'(out_data),    128'(32'h44));
    chk("flush_flush_cnt",   128'(flush_cnt),   128'(4'd1));
    chk("flush_stall_cnt",   128'(stall_cnt),   128'(4'd5));
    chk("flush_nz_data",     128'(nz_stage_data), 128'({32'h44, 32'h44, 32'h55}));
    chk("flush_nz_valid",    128'(nz_stage_valid), 128'(3'b100));
    tick();
    chk("reflush_flush_cnt", 128'(flush_cnt),   128'(4'd1));
    chk("reflush_valid",     128'(stage_valid), 128'(3'b000));
    chk("reflush_occupancy", 128'(occupancy),   128'(2'd0));
    chk("reflush_nz_out",    128'(nz_out_data), 128'(32'h44));

    // Saturation: 4-bit counter pins at 15, the 16-bit one keeps counting.
    flush_vec = 3'b000;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt",    128'(stall_cnt),    128'(4'd15));
    chk("sat_nz_stall_cnt", 128'(nz_stall_cnt), 128'(16'd26));

    // Refill, then a one-edge reset that also sees stall and flush requests.
    stall_vec = 3'b000;
    in_data   = 32'hAA;
    tick();
    in_data = 32'hBB;
    tick();
    in_data = 32'hCC;
    tick();
    chk("pre_reset_stage_data", 128'(stage_data), 128'({32'hAA, 32'hBB, 32'hCC}));
    reset_n   = 1'b0;
    stall_vec = 3'b100;
    flush_vec = 3'b111;
    #1;
    chk("in_reset_in_ready", 128'(in_ready), 128'(1'b0));
    tick();
    reset_n   = 1'b1;
    stall_vec = 3'b000;
    flush_vec = 3'b000;
    in_valid  = 1'b0;
    #1;
    chk("post_reset_valid",    128'(stage_valid), 128'(3'b000));
    chk("post_reset_data",     128'(stage_data),  128'(0));
    chk("post_reset_out",      128'({out_valid, out_data}), 128'(0));
    chk("post_reset_occ",      128'(occupancy),   128'(2'd0));
    chk("post_reset_counters", 128'({stall_cnt, flush_cnt}), 128'(8'h00));
    chk("post_reset_nz_data",  128'(nz_stage_data), 128'(0));
    chk("post_reset_nz_cnt",   128'({nz_stall_cnt, nz_flush_cnt}), 128'(0));

    // Flush overrides an all-stall on the oldest stage.
    in_valid = 1'b1;
    in_data  = 32'hDD;
    tick();
    tick();
    tick();
    stall_vec = 3'b100;
    flush_vec = 3'b100;
    tick();
    chk("flush_over_hold_valid", 128'(stage_valid), 128'(3'b011));
    chk("flush_over_hold_nz",    128'(nz_out_data), 128'(32'hDD));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
